// File: rtl/msx_slot_manager.sv
// msx_slot_manager
//   Primary/secondary slot selector for the MSX memory map. Holds the
//   primary slot register (I/O port A8h) and one secondary slot register
//   per expanded primary slot (memory FFFFh). It decodes the T80 bus into
//   active-low primary and sub-slot selects and page read strobes.
//
// Parameters
//   SLOTS     number of populated primary slots (1..4)
//   EXPANDED  bit s set: primary slot s is expanded (bits >= SLOTS ignored)
//   PRI_INIT  reset value of the primary register
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   addr, din               CPU address and write data
//   mreq_n .. rfrsh_n       T80 bus strobes
//   dout, dout_oe           readback data and its drive enable
//   SLTSL_n[SLOTS]          primary slot selects (active-low)
//   SUBSL_n[4*SLOTS]        sub-slot selects, bit 4s+k = slot s, sub-slot k
//   CS1_n/CS2_n/CS12_n/CS01_n  page read strobes
//   pri_reg                 current primary register
//
// Optional feature macro: SLOT_PRIMARY_READBACK_EN
//   defined   -> an I/O read of A8h returns pri_reg with dout_oe = 1
//   undefined -> A8h reads are not driven (the PPI port-A mirror answers)
module msx_slot_manager #(
  parameter int         SLOTS    = 4,
  parameter logic [3:0] EXPANDED = 4'b1000,
  parameter logic [7:0] PRI_INIT = 8'h00
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          addr,
  input  logic [7:0]           din,
  input  logic                 mreq_n,
  input  logic                 iorq_n,
  input  logic                 m1_n,
  input  logic                 rd_n,
  input  logic                 wr_n,
  input  logic                 rfrsh_n,
  output logic [7:0]           dout,
  output logic                 dout_oe,
  output logic [SLOTS-1:0]     SLTSL_n,
  output logic [4*SLOTS-1:0]   SUBSL_n,
  output logic                 CS1_n,
  output logic                 CS2_n,
  output logic                 CS12_n,
  output logic                 CS01_n,
  output logic [7:0]           pri_reg
);

  localparam logic [3:0] POP_MASK = 4'((1 << SLOTS) - 1);
  // Expansion bits above the populated range have no meaning.
  localparam logic [3:0] EXP = EXPANDED & POP_MASK;

  logic [1:0] page;
  logic [1:0] ps;
  logic [1:0] ps3;
  logic [1:0] ss;
  logic [7:0] sec [4];
  logic       mem_cyc;
  logic       io_a8;
  logic       intercept;
  logic       sel;
  logic       rd_cyc;
  logic       wr_act;
  logic       wr_prev;
  logic       commit;

  assign page    = addr[15:14];
  assign ps      = pri_reg[{page, 1'b0} +: 2];
  assign ss      = sec[ps][{page, 1'b0} +: 2];
  assign ps3     = pri_reg[7:6];
  assign mem_cyc = ~mreq_n & rfrsh_n;
  // m1_n high excludes interrupt acknowledge, which also drives iorq_n low.
  assign io_a8   = ~iorq_n & m1_n & (addr[7:0] == 8'hA8);
  // FFFFh is only the secondary register when page 3 maps an expanded slot.
  assign intercept = mem_cyc & (addr == 16'hFFFF) & EXP[ps3];
  assign sel     = mem_cyc & POP_MASK[ps];
  assign rd_cyc  = mem_cyc & ~rd_n;

  // Commit only on the first cycle of a write so wait states cannot repeat it.
  assign wr_act  = ~wr_n & (io_a8 | intercept);
  assign commit  = wr_act & ~wr_prev;

  always_comb begin
    SLTSL_n = '1;
    SUBSL_n = '1;
    for (int s = 0; s < SLOTS; s++) begin
      SLTSL_n[s] = ~(sel && (ps == 2'(s)));
      for (int k = 0; k < 4; k++) begin
        SUBSL_n[4*s+k] = ~(sel && (ps == 2'(s)) && EXP[s] && !intercept
                           && (ss == 2'(k)));
      end
    end
  end

  assign CS1_n  = ~(rd_cyc & (page == 2'd1));
  assign CS2_n  = ~(rd_cyc & (page == 2'd2));
  assign CS12_n = ~(rd_cyc & ((page == 2'd1) | (page == 2'd2)));
  assign CS01_n = ~(rd_cyc & ((page == 2'd0) | (page == 2'd1)));

  always_comb begin
    dout    = 8'h00;
    dout_oe = 1'b0;
    if (intercept && !rd_n) begin
      // Secondary register reads back inverted, as on real MSX hardware.
      dout    = ~sec[ps3];
      dout_oe = 1'b1;
    end
`ifdef SLOT_PRIMARY_READBACK_EN
    else if (io_a8 && !rd_n) begin
      dout    = pri_reg;
      dout_oe = 1'b1;
    end
`endif
  end

  // Register stage: edge detect and primary register.
  // wr_prev resets high so a strobe held across reset release is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_prev <= 1'b1;
      pri_reg <= PRI_INIT;
    end else begin
      wr_prev <= wr_act;
      if (commit && io_a8) pri_reg <= din;
    end
  end

  // Secondary registers exist only for expanded slots.
  for (genvar s = 0; s < 4; s++) begin : g_sec
    if (EXP[s]) begin : g_exp
      always_ff @(posedge clk) begin
        if (reset) sec[s] <= 8'h00;
        else if (commit && intercept && (ps3 == 2'(s))) sec[s] <= din;
      end
    end else begin : g_flat
      assign sec[s] = 8'h00;
    end
  end

endmodule

// File: tb/tb_msx_slot_manager.sv
module tb_msx_slot_manager;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic [7:0]  din;
  logic        mreq_n, iorq_n, m1_n, rd_n, wr_n, rfrsh_n;

  logic [7:0]  dout;
  logic        dout_oe;
  logic [3:0]  SLTSL_n;
  logic [15:0] SUBSL_n;
  logic        CS1_n, CS2_n, CS12_n, CS01_n;
  logic [7:0]  pri_reg;

  logic [7:0]  dout2;
  logic        dout_oe2;
  logic [1:0]  SLTSL_n2;
  logic [7:0]  SUBSL_n2;
  logic        cs1_2, cs2_2, cs12_2, cs01_2;
  logic [7:0]  pri_reg2;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  msx_slot_manager #(.SLOTS(4), .EXPANDED(4'b1000), .PRI_INIT(8'hE4)) dut (
    .clk(clk), .reset(reset), .addr(addr), .din(din),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .m1_n(m1_n), .rd_n(rd_n),
    .wr_n(wr_n), .rfrsh_n(rfrsh_n),
    .dout(dout), .dout_oe(dout_oe), .SLTSL_n(SLTSL_n), .SUBSL_n(SUBSL_n),
    .CS1_n(CS1_n), .CS2_n(CS2_n), .CS12_n(CS12_n), .CS01_n(CS01_n),
    .pri_reg(pri_reg)
  );

  msx_slot_manager #(.SLOTS(2), .EXPANDED(4'b1000), .PRI_INIT(8'h03)) dut2 (
    .clk(clk), .reset(reset), .addr(addr), .din(din),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .m1_n(m1_n), .rd_n(rd_n),
    .wr_n(wr_n), .rfrsh_n(rfrsh_n),
    .dout(dout2), .dout_oe(dout_oe2), .SLTSL_n(SLTSL_n2), .SUBSL_n(SUBSL_n2),
    .CS1_n(cs1_2), .CS2_n(cs2_2), .CS12_n(cs12_2), .CS01_n(cs01_2),
    .pri_reg(pri_reg2)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic bus_idle();
    mreq_n = 1'b1; iorq_n = 1'b1; m1_n = 1'b1;
    rd_n = 1'b1; wr_n = 1'b1; rfrsh_n = 1'b1;
  endtask

  // Drive a new bus state just after a falling edge; checks follow at +1.
  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic mem_rd(input logic [15:0] a);
    at_neg();
    bus_idle();
    addr = a; mreq_n = 1'b0; rd_n = 1'b0;
    #1;
  endtask

  task automatic io_wr(input logic [7:0] d);
    at_neg();
    bus_idle();
    addr = 16'h00A8; din = d; iorq_n = 1'b0; wr_n = 1'b0;
    at_neg();
    bus_idle();
    at_neg();
  endtask

  task automatic mem_wr(input logic [15:0] a, input logic [7:0] d);
    at_neg();
    bus_idle();
    addr = a; din = d; mreq_n = 1'b0; wr_n = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; addr = 16'h0000; din = 8'h00;
    bus_idle();
    repeat (2) @(posedge clk);
    at_neg(); #1;
    chk("rst_pri", 32'(pri_reg), 32'hE4);
    chk("rst_sltsl", 32'(SLTSL_n), 32'hF);
    chk("rst_subsl", 32'(SUBSL_n), 32'hFFFF);
    chk("rst_oe", 32'(dout_oe), 32'h0);
    at_neg(); reset = 1'b0;
    at_neg();

    // Page 1 read, slot 1 from E4h
    mem_rd(16'h4000);
    chk("p1_sltsl", 32'(SLTSL_n), 32'b1101);
    chk("p1_cs", 32'({CS1_n, CS2_n, CS12_n, CS01_n}), 32'b0100);
    chk("p1_subsl", 32'(SUBSL_n), 32'hFFFF);
    chk("s2_p1_sltsl", 32'(SLTSL_n2), 32'b10);
    // Page 0 of the 2-slot instance maps unpopulated slot 3
    mem_rd(16'h0000);
    chk("p0_sltsl", 32'(SLTSL_n), 32'b1110);
    chk("p0_cs", 32'({CS1_n, CS2_n, CS12_n, CS01_n}), 32'b1110);
    chk("s2_open_sltsl", 32'(SLTSL_n2), 32'b11);
    chk("s2_open_oe", 32'(dout_oe2), 32'h0);

    // A8h write held for 5 clocks; data changed mid-hold must not recommit
    at_neg(); bus_idle();
    addr = 16'h00A8; din = 8'hC0; iorq_n = 1'b0; wr_n = 1'b0;
    at_neg(); at_neg();
    din = 8'h11;
    at_neg(); at_neg(); at_neg();
    #1;
    chk("hold_pri", 32'(pri_reg), 32'hC0);
    bus_idle();
    mem_rd(16'hC000);
    chk("c000_sltsl", 32'(SLTSL_n), 32'b0111);
    chk("c000_subsl", 32'(SUBSL_n), 32'hEFFF);
    chk("c000_cs", 32'({CS1_n, CS2_n, CS12_n, CS01_n}), 32'b1111);
    mem_rd(16'h8000);
    chk("8000_c0_sltsl", 32'(SLTSL_n), 32'b1110);
    chk("8000_c0_subsl", 32'(SUBSL_n), 32'hFFFF);

    // Secondary register write and inverted readback
    mem_wr(16'hFFFF, 8'h9C);
    chk("ffw_sltsl", 32'(SLTSL_n), 32'b0111);
    chk("ffw_subsl", 32'(SUBSL_n), 32'hFFFF);
    chk("ffw_oe", 32'(dout_oe), 32'h0);
    at_neg(); bus_idle();
    mem_rd(16'hFFFF);
    chk("ffr_dout", 32'(dout), 32'h63);
    chk("ffr_oe", 32'(dout_oe), 32'h1);
    chk("ffr_subsl", 32'(SUBSL_n), 32'hFFFF);
    chk("ffr_sltsl", 32'(SLTSL_n), 32'b0111);

    // Map pages 1..3 to slot 3; sec = 9Ch -> sub 3 / 1 / 2
    io_wr(8'hFC);
    mem_rd(16'h4000);
    chk("sub_p1", 32'(SUBSL_n), 32'h7FFF);
    mem_rd(16'h8000);
    chk("sub_p2", 32'(SUBSL_n), 32'hDFFF);
    mem_rd(16'hC000);
    chk("sub_p3", 32'(SUBSL_n), 32'hBFFF);

    // Refresh at FFFFh with a write strobe: nothing selected, no commit
    at_neg(); bus_idle();
    addr = 16'hFFFF; din = 8'h00; mreq_n = 1'b0; rfrsh_n = 1'b0; wr_n = 1'b0;
    #1;
    chk("rf_sltsl", 32'(SLTSL_n), 32'hF);
    chk("rf_subsl", 32'(SUBSL_n), 32'hFFFF);
    chk("rf_cs", 32'({CS1_n, CS2_n, CS12_n, CS01_n}), 32'hF);
    at_neg(); at_neg(); bus_idle();
    mem_rd(16'hFFFF);
    chk("rf_nocommit", 32'(dout), 32'h63);

    // Interrupt acknowledge at A8h never decodes
    at_neg(); bus_idle();
    addr = 16'h00A8; din = 8'h00; iorq_n = 1'b0; m1_n = 1'b0; wr_n = 1'b0;
    at_neg(); at_neg(); bus_idle();
    at_neg(); #1;
    chk("inta_pri", 32'(pri_reg), 32'hFC);

    // Write strobe held across reset release must not commit
    at_neg(); reset = 1'b1;
    addr = 16'h00A8; din = 8'h55; iorq_n = 1'b0; wr_n = 1'b0;
    at_neg(); at_neg();
    reset = 1'b0;
    at_neg(); at_neg(); at_neg(); #1;
    chk("rsthold_pri", 32'(pri_reg), 32'hE4);
    bus_idle();
    at_neg();
    io_wr(8'h55);
    #1;
    chk("fresh_pri", 32'(pri_reg), 32'h55);

    // Primary readback at A8h
    io_wr(8'h5A);
    at_neg(); bus_idle();
    addr = 16'h00A8; iorq_n = 1'b0; rd_n = 1'b0;
    #1;
`ifdef SLOT_PRIMARY_READBACK_EN
    chk("a8rd_dout", 32'(dout), 32'h5A);
    chk("a8rd_oe", 32'(dout_oe), 32'h1);
`else
    chk("a8rd_oe", 32'(dout_oe), 32'h0);
`endif
    chk("a8rd_sltsl", 32'(SLTSL_n), 32'hF);
    at_neg(); bus_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
